// File: rtl/ysyx_220053_mem_arb.sv
// ysyx_220053_mem_arb: two-port arbiter (instruction fetch / load-store) in
// front of a single combinational-read memory port.
// One access takes two cycles: ACCESS drives the memory, RESP returns the data.
// Define YSYX_220053_ARB_RR_EN to get round-robin arbitration. Without it,
// LS has fixed priority and a starvation guard force-grants IF.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transaction in flight, arbitration open
// S_ACCESS | memory port driven from latched request, rdata captured at end
// S_RESP   | owner's rvalid strobe, arbitration open for back-to-back use
module ysyx_220053_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [63:0] ls_addr,
  input  logic [2:0]  ls_op,
  input  logic        ls_wen,
  input  logic [63:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic [63:0] mem_addr,
  output logic [2:0]  mem_op,
  output logic [63:0] mem_wdata,
  output logic        mem_wen,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t state, state_nxt;
  logic   owner_ls;
  logic   lat_wen;
  logic   arb_ok;
  logic   grant_if;
  logic   if_acc;
  logic   ls_acc;

`ifdef YSYX_220053_ARB_RR_EN
  logic last_ls;

  // Round-robin: on contention the side not granted last time wins.
  always_comb begin
    grant_if = if_req && (!ls_req || last_ls);
  end

  // Remember who was granted most recently; reset says IF went last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_ls <= 1'b0;
    else if (if_acc) last_ls <= 1'b0;
    else if (ls_acc) last_ls <= 1'b1;
  end
`else
  logic [3:0] starve_cnt;

  // Fixed priority for LS, overridden once IF has waited STARVE_MAX cycles.
  always_comb begin
    grant_if = if_req && (!ls_req || (starve_cnt == 4'(STARVE_MAX)));
  end

  // Count cycles IF waits without acceptance, saturating at STARVE_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              starve_cnt <= 4'd0;
    else if (!if_req || if_acc)           starve_cnt <= 4'd0;
    else if (starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  // Ready/accept decode; arbitration is only open in IDLE and RESP.
  always_comb begin
    arb_ok   = !rst && ((state == S_IDLE) || (state == S_RESP));
    if_ready = arb_ok && grant_if;
    ls_ready = arb_ok && ls_req && !grant_if;
    if_acc   = if_req && if_ready;
    ls_acc   = ls_req && ls_ready;
  end

  // Next-state and response strobes.
  always_comb begin
    state_nxt = state;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    mem_wen   = 1'b0;
    case (state)
      S_IDLE:   if (if_acc || ls_acc) state_nxt = S_ACCESS;
      S_ACCESS: begin
        mem_wen   = lat_wen;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if_rvalid = !owner_ls;
        ls_rvalid = owner_ls;
        state_nxt = (if_acc || ls_acc) ? S_ACCESS : S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Request latch on accept and read-data capture at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= 64'd0;
      mem_op    <= 3'b011;
      mem_wdata <= 64'd0;
      lat_wen   <= 1'b0;
      owner_ls  <= 1'b0;
      if_rdata  <= 32'd0;
      ls_rdata  <= 64'd0;
    end else begin
      if (if_acc) begin
        mem_addr  <= if_addr;
        mem_op    <= 3'b100;
        mem_wdata <= 64'd0;
        lat_wen   <= 1'b0;
        owner_ls  <= 1'b0;
      end else if (ls_acc) begin
        mem_addr  <= ls_addr;
        mem_op    <= ls_op;
        mem_wdata <= ls_wdata;
        lat_wen   <= ls_wen;
        owner_ls  <= 1'b1;
      end
      if (state == S_ACCESS) begin
        if (owner_ls) ls_rdata <= lat_wen ? 64'd0 : mem_rdata;
        else          if_rdata <= mem_rdata[31:0];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220053_mem_arb.sv
// Directed bench for ysyx_220053_mem_arb: reset values, single-port load,
// store and fetch timing, contention grant pattern, and reset mid-access.
module tb_ysyx_220053_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic [63:0] ls_addr;
  logic [2:0]  ls_op;
  logic        ls_wen;
  logic [63:0] ls_wdata;
  logic        ls_ready;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic [63:0] mem_addr;
  logic [2:0]  mem_op;
  logic [63:0] mem_wdata;
  logic        mem_wen;
  logic [63:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  ysyx_220053_mem_arb #(.STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_op     (ls_op),
    .ls_wen    (ls_wen),
    .ls_wdata  (ls_wdata),
    .ls_ready  (ls_ready),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_addr  (mem_addr),
    .mem_op    (mem_op),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_grant [12];

  initial begin
`ifdef YSYX_220053_ARB_RR_EN
    exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
                  2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`else
    exp_grant = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00,
                  2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`endif
    rst = 1'b1;
    if_req = 1'b1; if_addr = 64'h1000;
    ls_req = 1'b1; ls_addr = 64'h2000; ls_op = 3'b000; ls_wen = 1'b0;
    ls_wdata = 64'd0; mem_rdata = 64'd0;
    cyc(); cyc();
    // reset values, even with both requests asserted
    chk("rst_if_ready", {63'd0, if_ready}, 64'd0);
    chk("rst_ls_ready", {63'd0, ls_ready}, 64'd0);
    chk("rst_rvalid", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
    chk("rst_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("rst_mem_op", {61'd0, mem_op}, 64'd3);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_rdata", ls_rdata | {32'd0, if_rdata}, 64'd0);
    if_req = 1'b0; ls_req = 1'b0;
    rst = 1'b0;
    cyc();

    // LS-only load
    ls_req = 1'b1; ls_addr = 64'h8000_0004; ls_op = 3'b000; ls_wen = 1'b0;
    #1;
    chk("ld_ls_ready", {63'd0, ls_ready}, 64'd1);
    chk("ld_if_ready", {63'd0, if_ready}, 64'd0);
    cyc();
    ls_req = 1'b0; mem_rdata = 64'hFFFF_FFFF_0000_0000;
    #1;
    chk("ld_mem_addr", mem_addr, 64'h8000_0004);
    chk("ld_mem_op", {61'd0, mem_op}, 64'd0);
    chk("ld_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("ld_early_rvalid", {63'd0, ls_rvalid}, 64'd0);
    cyc();
    mem_rdata = 64'd0;
    chk("ld_rvalid", {63'd0, ls_rvalid}, 64'd1);
    chk("ld_if_rvalid", {63'd0, if_rvalid}, 64'd0);
    chk("ld_rdata", ls_rdata, 64'hFFFF_FFFF_0000_0000);
    cyc();
    chk("ld_rvalid_drop", {63'd0, ls_rvalid}, 64'd0);

    // LS store
    ls_req = 1'b1; ls_addr = 64'h8000_0010; ls_op = 3'b001; ls_wen = 1'b1;
    ls_wdata = 64'h55;
    #1;
    chk("st_ls_ready", {63'd0, ls_ready}, 64'd1);
    chk("st_wen_pre", {63'd0, mem_wen}, 64'd0);
    cyc();
    ls_req = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("st_mem_wen", {63'd0, mem_wen}, 64'd1);
    chk("st_mem_wdata", mem_wdata, 64'h55);
    chk("st_mem_op", {61'd0, mem_op}, 64'd1);
    cyc();
    chk("st_wen_post", {63'd0, mem_wen}, 64'd0);
    chk("st_rvalid", {63'd0, ls_rvalid}, 64'd1);
    chk("st_rdata", ls_rdata, 64'd0);
    cyc();

    // IF fetch
    if_req = 1'b1; if_addr = 64'h8000_0000;
    #1;
    chk("if_ready", {63'd0, if_ready}, 64'd1);
    cyc();
    if_req = 1'b0; mem_rdata = 64'h1234_5678_0000_0013;
    #1;
    chk("if_mem_op", {61'd0, mem_op}, 64'd4);
    chk("if_mem_addr", mem_addr, 64'h8000_0000);
    chk("if_mem_wen", {63'd0, mem_wen}, 64'd0);
    cyc();
    mem_rdata = 64'd0;
    chk("if_rvalid", {63'd0, if_rvalid}, 64'd1);
    chk("if_ls_rvalid", {63'd0, ls_rvalid}, 64'd0);
    chk("if_rdata", {32'd0, if_rdata}, 64'h13);
    cyc();

    // contention: both requesting every cycle
    if_req = 1'b1; if_addr = 64'h100;
    ls_req = 1'b1; ls_addr = 64'h200; ls_op = 3'b011; ls_wen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("grant_%0d", i), {62'd0, if_ready, ls_ready}, {62'd0, exp_grant[i]});
      cyc();
    end
    if_req = 1'b0; ls_req = 1'b0;
    cyc(); cyc(); cyc();

    // reset pulse in the ACCESS cycle of a store
    ls_req = 1'b1; ls_addr = 64'h8000_0020; ls_op = 3'b011; ls_wen = 1'b1;
    ls_wdata = 64'hAA;
    #1;
    chk("rs_ls_ready", {63'd0, ls_ready}, 64'd1);
    cyc();
    ls_req = 1'b0;
    #1;
    chk("rs_wen_before", {63'd0, mem_wen}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rs_wen_drop", {63'd0, mem_wen}, 64'd0);
    chk("rs_mem_addr", mem_addr, 64'd0);
    #1;
    rst = 1'b0;
    cyc();
    chk("rs_no_rvalid_1", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
    cyc();
    chk("rs_no_rvalid_2", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
    // next request served normally
    ls_req = 1'b1; ls_addr = 64'h8000_0030; ls_op = 3'b101; ls_wen = 1'b0;
    #1;
    chk("rs_next_ready", {63'd0, ls_ready}, 64'd1);
    cyc();
    ls_req = 1'b0; mem_rdata = 64'h0000_0000_0000_00C3;
    #1;
    chk("rs_next_op", {61'd0, mem_op}, 64'd5);
    cyc();
    chk("rs_next_rvalid", {63'd0, ls_rvalid}, 64'd1);
    chk("rs_next_rdata", ls_rdata, 64'hC3);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_mem_arb.md
YSYX_220053_MEM_ARB -- requirements
Module: ysyx_220053_mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive denied cycles after which a waiting IF request is force-granted; legal range 1..15.
REQ-002 clk  input  1  single clock, all state updates on posedge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 if_req  input  1  instruction fetch request.
REQ-005 if_addr  input  64  fetch byte address.
REQ-006 if_ready  output  1  IF request accepted this cycle.
REQ-007 if_rvalid  output  1  one-cycle IF response strobe.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 ls_req  input  1  load/store request.
REQ-010 ls_addr  input  64  load/store byte address.
REQ-011 ls_op  input  3  MemOp encoding: 000 lw, 001 lb, 010 lh, 011 ld, 100 lwu, 101 lbu, 110 lhu.
REQ-012 ls_wen  input  1  1 = store, 0 = load.
REQ-013 ls_wdata  input  64  store data, LSB-aligned.
REQ-014 ls_ready  output  1  LS request accepted this cycle.
REQ-015 ls_rvalid  output  1  one-cycle LS response or store acknowledge.
REQ-016 ls_rdata  output  64  load result; 0 for stores.
REQ-017 mem_addr  output  64  to memory raddr.
REQ-018 mem_op  output  3  to memory MemOp.
REQ-019 mem_wdata  output  64  to memory wdata.
REQ-020 mem_wen  output  1  to memory MemWen.
REQ-021 mem_rdata  input  64  from memory rdata (combinational read).

Function
REQ-022 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept; ACCESS->RESP unconditionally; RESP->ACCESS on accept, else RESP->IDLE.
REQ-023 Accept allowed only in IDLE or RESP; if_ready/ls_ready combinational, at most one high per cycle; accept = req && ready.
REQ-024 On accept, requester addr/op/wdata/wen and owner ID are latched; requester holds req and fields stable until ready.
REQ-025 IF accesses use op 3'b100 and wen 0; if_rdata = captured mem_rdata[31:0].
REQ-026 In ACCESS: mem_* driven from latches; mem_wen = latched wen for exactly that cycle; mem_rdata captured at its closing posedge.
REQ-027 Outside ACCESS: mem_wen = 0; mem_addr/mem_op/mem_wdata hold last latched values.
REQ-028 In RESP: exactly the owner's rvalid = 1 for one cycle with captured data; store response rdata = 0.
REQ-029 Latency: accept at cycle N -> memory access N+1 -> rvalid N+2; peak throughput one access per 2 cycles.
REQ-030 Fixed priority (default build): LS wins over IF, except IF wins when starve counter == STARVE_MAX.
REQ-031 Starve counter (4 bit): +1 each cycle if_req high and IF not accepted, saturates at STARVE_MAX; cleared on IF accept or if_req low.
REQ-032 Single requester: granted immediately when arbitration allowed.

Reset
REQ-033 rst asserted at any time: state IDLE, all rvalid/ready/mem_wen 0, mem_addr/mem_wdata/if_rdata/ls_rdata 0, mem_op 3'b011, starve counter 0, last-grant = IF.
REQ-034 Reset mid-ACCESS drops the transaction; no write occurs at the next posedge and no rvalid follows.

Configuration
REQ-035 Macro YSYX_220053_ARB_RR_EN defined: round-robin; on contention the requester not granted last wins; starve counter ignored (held 0).
REQ-036 Macro undefined: fixed priority with starvation guard per REQ-030/031.

Verification
REQ-037 LS-only load ls_addr=0x80000004, ls_op=000, mem_rdata=0xFFFFFFFF_00000000 at ACCESS -> ls_ready N, mem_addr valid N+1, ls_rvalid N+2, ls_rdata=0xFFFFFFFF_00000000.
REQ-038 LS store ls_wdata=0x55, ls_op=001 -> mem_wen high only cycle N+1, ls_rvalid N+2 with ls_rdata=0.
REQ-039 Both requesting every cycle, default build, STARVE_MAX=4 -> LS accepted until counter hits 4, then IF accepted; pattern repeats, no IF wait > 4 arbitration opportunities beyond.
REQ-040 Same contention with YSYX_220053_ARB_RR_EN -> grants alternate LS, IF, LS, IF; accepts spaced 2 cycles.
REQ-041 rst pulsed during ACCESS of a store -> mem_wen drops immediately, no ls_rvalid, FSM IDLE, next request served normally.
REQ-042 IF fetch if_addr=0x80000000, mem_rdata=0x12345678_00000013 -> mem_op=100, if_rvalid at N+2, if_rdata=0x00000013.
